// File: rtl/sdram_burst_responder.sv
// Burst-read responder for the video SDRAM port: prefetches words from a
// single-word memory port into a small FIFO and streams them back one per cycle.
//
// state | meaning
// IDLE  | waiting for a burst request
// BURST | fetching into the FIFO and delivering one word per cycle
// ABORT | requester ended the burst; flush FIFO, retire any outstanding read
module sdram_burst_responder #(
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 256
) (
    input  logic        clk_sys_131_072,
    input  logic        reset,
    input  logic        sd_rd,
    input  logic [24:0] sd_rd_addr,
    input  logic        sd_end_burst,
    output logic        sd_data_available,
    output logic [15:0] sd_out,
    output logic        busy,
    output logic        burst_done,
    output logic        mem_rd,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 9;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        ABORT
    } state_t;

    state_t state, state_next;

    logic [24:0]   fetch_addr;
    logic [CW-1:0] fetched;
    logic [CW-1:0] delivered;
    logic [15:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic accept;
    logic issue;
    logic push;
    logic pop;
    logic flush;
    logic ack_take;
    logic last_pop;

    assign ack_take = mem_rd && mem_ack;
    assign busy     = (state != IDLE);
    assign last_pop = pop && (delivered == CW'(MAX_BURST - 1));

    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (sd_rd) begin
                    accept     = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                // burst_done is high in the cycle carrying the final strobe
                if (burst_done) begin
                    state_next = IDLE;
                end else if (sd_end_burst) begin
                    state_next = ABORT;
                end else begin
                    push  = ack_take;
                    pop   = (count != '0);
                    issue = !mem_rd && (fetched < CW'(MAX_BURST))
                            && (count < (AW+1)'(DEPTH));
                end
            end
            ABORT: begin
                flush = 1'b1;
                if (!mem_rd || mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_131_072) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_q;
        end
    end

    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            sd_data_available <= 1'b0;
            sd_out            <= '0;
            burst_done        <= 1'b0;
            mem_rd            <= 1'b0;
            mem_addr          <= '0;
            fetch_addr        <= '0;
            fetched           <= '0;
            delivered         <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
        end else begin
            sd_data_available <= 1'b0;
            burst_done        <= 1'b0;

            if (accept) begin
                fetch_addr <= sd_rd_addr;
                fetched    <= '0;
                delivered  <= '0;
            end

            // an ack always retires the read, even when its data is discarded
            if (ack_take) begin
                mem_rd <= 1'b0;
            end
            if (issue) begin
                mem_rd   <= 1'b1;
                mem_addr <= fetch_addr;
            end

            if (push) begin
                fetch_addr <= fetch_addr + 25'd1;
                fetched    <= fetched + CW'(1);
                wr_ptr     <= wr_ptr + AW'(1);
            end

            if (pop) begin
                sd_out            <= fifo_mem[rd_ptr];
                sd_data_available <= 1'b1;
                delivered         <= delivered + CW'(1);
                rd_ptr            <= rd_ptr + AW'(1);
            end

            if (last_pop) begin
                burst_done <= 1'b1;
            end

            if (flush || accept) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench for sdram_burst_responder: expected words are queued when a
// burst is requested and checked against each sd_data_available strobe.
module tb_sdram_burst_responder;

    localparam int DEPTH = 4;
    localparam int MAXB  = 8;

    logic        clk_sys_131_072 = 1'b0;
    logic        reset;
    logic        sd_rd;
    logic [24:0] sd_rd_addr;
    logic        sd_end_burst;
    logic        sd_data_available;
    logic [15:0] sd_out;
    logic        busy;
    logic        burst_done;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_q;

    logic        manual;
    logic        man_ack;
    logic [15:0] man_q;
    logic        mdl_ack;
    logic [15:0] mdl_q;

    assign mem_ack = manual ? man_ack : mdl_ack;
    assign mem_q   = manual ? man_q   : mdl_q;

    always #5 clk_sys_131_072 = ~clk_sys_131_072;

    sdram_burst_responder #(.DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk_sys_131_072   (clk_sys_131_072),
        .reset             (reset),
        .sd_rd             (sd_rd),
        .sd_rd_addr        (sd_rd_addr),
        .sd_end_burst      (sd_end_burst),
        .sd_data_available (sd_data_available),
        .sd_out            (sd_out),
        .busy              (busy),
        .burst_done        (burst_done),
        .mem_rd            (mem_rd),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_q             (mem_q)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [24:0] addr_log[$];
    int          n_strobe  = 0;
    int          n_acked   = 0;
    logic        prev_done = 1'b0;
    logic        occ_track = 1'b0;
    int          occ_base  = 0;
    int          max_occ   = 0;
    exp_t        mon_e;
    int          mon_occ;

    // memory model: acks after a latency drawn from [lat_min, lat_max]
    int lat_min = 1;
    int lat_max = 1;
    int cur_lat = 1;
    int wcnt    = 0;

    initial begin
        mdl_ack = 1'b0;
        mdl_q   = '0;
        forever begin
            @(negedge clk_sys_131_072);
            if (mdl_ack) begin
                mdl_ack = 1'b0;
            end else if (mem_rd && !manual) begin
                wcnt++;
                if (wcnt >= cur_lat) begin
                    mdl_ack = 1'b1;
                    mdl_q   = mem_addr[15:0];
                    wcnt    = 0;
                    cur_lat = int'($urandom_range(lat_max, lat_min));
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(posedge clk_sys_131_072) begin
        if (!reset && mem_rd && mem_ack) begin
            n_acked <= n_acked + 1;
            addr_log.push_back(mem_addr);
        end
    end

    always @(posedge clk_sys_131_072) begin
        #1;
        if (!reset) begin
            if (prev_done) check_val("busy_after_done", 32'(busy), 32'd0);
            if (sd_data_available) begin
                n_strobe++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_strobe", 32'(sd_data_available), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("data", 32'(sd_out), 32'(mon_e.d));
                    check_val("burst_done", 32'(burst_done), 32'(mon_e.last));
                    if (mon_e.last) check_val("busy_at_done", 32'(busy), 32'd1);
                end
            end else if (burst_done) begin
                check_val("done_without_strobe", 32'(burst_done), 32'd0);
            end
            if (occ_track) begin
                mon_occ = (n_acked - n_strobe) - occ_base;
                if (mon_occ > max_occ) max_occ = mon_occ;
            end
        end
        prev_done = burst_done && !reset;
    end

    task automatic start_burst(input logic [24:0] a, input int n_words, input bit full,
                               input logic with_end);
        for (int i = 0; i < n_words; i++) begin
            logic [24:0] wa;
            exp_t        e;
            wa     = a + 25'(i);
            e.d    = wa[15:0];
            e.last = full && (i == MAXB - 1);
            exp_q.push_back(e);
        end
        sd_rd        = 1'b1;
        sd_rd_addr   = a;
        sd_end_burst = with_end;
        @(negedge clk_sys_131_072);
        sd_rd        = 1'b0;
        sd_end_burst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < 400) begin
            @(negedge clk_sys_131_072);
            g++;
        end
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic serve_one(input string tag);
        int g = 0;
        while (!mem_rd && g < 50) begin
            @(negedge clk_sys_131_072);
            g++;
        end
        check_val({tag, "_rd"}, 32'(mem_rd), 32'd1);
        man_ack = 1'b1;
        man_q   = mem_addr[15:0];
        @(negedge clk_sys_131_072);
        man_ack = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_avail"}, 32'(sd_data_available), 32'd0);
        check_val({tag, "_out"},   32'(sd_out), 32'd0);
        check_val({tag, "_busy"},  32'(busy), 32'd0);
        check_val({tag, "_done"},  32'(burst_done), 32'd0);
        check_val({tag, "_rd"},    32'(mem_rd), 32'd0);
        check_val({tag, "_addr"},  32'(mem_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] wrap_exp [4];
        int base;
        int g;

        reset        = 1'b1;
        sd_rd        = 1'b0;
        sd_rd_addr   = '0;
        sd_end_burst = 1'b0;
        manual       = 1'b0;
        man_ack      = 1'b0;
        man_q        = '0;
        repeat (3) @(negedge clk_sys_131_072);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk_sys_131_072);

        // basic burst, ack one cycle after mem_rd
        start_burst(25'h0000100, MAXB, 1'b1, 1'b0);
        wait_idle("basic");

        // early end while a read is outstanding
        manual = 1'b1;
        base   = n_strobe;
        start_burst(25'h0000020, 3, 1'b0, 1'b0);
        repeat (3) serve_one("ee");
        g = 0;
        while ((n_strobe - base) < 3 && g < 50) begin
            @(negedge clk_sys_131_072);
            g++;
        end
        check_val("ee_three_strobes", 32'(n_strobe - base), 32'd3);
        check_val("ee_outstanding", 32'(mem_rd), 32'd1);
        sd_end_burst = 1'b1;
        @(negedge clk_sys_131_072);
        sd_end_burst = 1'b0;
        check_val("ee_busy_abort", 32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check_val("ee_rd_held", 32'(mem_rd), 32'd1);
            @(negedge clk_sys_131_072);
        end
        man_ack = 1'b1;
        man_q   = mem_addr[15:0];
        @(negedge clk_sys_131_072);
        man_ack = 1'b0;
        check_val("ee_idle_after_ack", 32'(busy), 32'd0);
        check_val("ee_rd_dropped", 32'(mem_rd), 32'd0);
        repeat (4) @(negedge clk_sys_131_072);
        check_val("ee_total_strobes", 32'(n_strobe - base), 32'd3);
        manual = 1'b0;

        // 25-bit address wrap
        addr_log.delete();
        start_burst(25'h1FFFFFE, MAXB, 1'b1, 1'b0);
        wait_idle("wrap");
        wrap_exp[0] = 25'h1FFFFFE;
        wrap_exp[1] = 25'h1FFFFFF;
        wrap_exp[2] = 25'h0000000;
        wrap_exp[3] = 25'h0000001;
        check_val("wrap_reads", 32'(addr_log.size()), 32'(MAXB));
        for (int k = 0; k < 4; k++) begin
            check_val("wrap_addr", 32'(addr_log[k]), 32'(wrap_exp[k]));
        end

        // slow memory with random latency
        lat_min  = 1;
        lat_max  = 10;
        occ_base = n_acked - n_strobe;
        max_occ  = 0;
        occ_track = 1'b1;
        for (int b = 0; b < 3; b++) begin
            start_burst(25'h0001000 + 25'(b * 'h100), MAXB, 1'b1, 1'b0);
            wait_idle("slow");
        end
        occ_track = 1'b0;
        check_val("slow_occ_le_depth", 32'(max_occ <= DEPTH), 32'd1);
        lat_min = 2;
        lat_max = 2;

        // request while busy is ignored
        start_burst(25'h0000300, MAXB, 1'b1, 1'b0);
        repeat (4) @(negedge clk_sys_131_072);
        sd_rd      = 1'b1;
        sd_rd_addr = 25'h0000500;
        @(negedge clk_sys_131_072);
        sd_rd = 1'b0;
        wait_idle("busy_req");

        // sd_rd together with sd_end_burst in IDLE starts normally
        start_burst(25'h0000040, MAXB, 1'b1, 1'b1);
        wait_idle("rd_with_end");
        lat_min = 1;
        lat_max = 1;

        // reset mid-burst, then a late ack
        manual = 1'b1;
        start_burst(25'h0000600, 0, 1'b0, 1'b0);
        g = 0;
        while (!mem_rd && g < 50) begin
            @(negedge clk_sys_131_072);
            g++;
        end
        check_val("rst_rd_before", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys_131_072);
        check_outputs_zero("mid_reset");
        reset   = 1'b0;
        man_ack = 1'b1;
        man_q   = 16'hDEAD;
        @(negedge clk_sys_131_072);
        man_ack = 1'b0;
        repeat (3) @(negedge clk_sys_131_072);
        check_val("late_ack_busy", 32'(busy), 32'd0);
        check_val("late_ack_rd", 32'(mem_rd), 32'd0);
        manual = 1'b0;
        start_burst(25'h0000700, MAXB, 1'b1, 1'b0);
        wait_idle("post_reset");

        repeat (2) @(negedge clk_sys_131_072);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
